// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared types and constants for the instruction fetch unit.
//   - fetch_state_e : fetch FSM states
//   - WORD_W        : instruction / address word width
//   - TIMEOUT       : max cycles a read may stay outstanding without mem_ack
//   - TIMER_W/TC    : timeout counter width and terminal-count value
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned TIMER_W = 4;

  // The counter holds the number of unacknowledged cycles already spent in
  // WAIT, so the cycle in which it reads TIMEOUT-1 is the TIMEOUT-th one.
  localparam logic [TIMER_W-1:0] TIMER_TC = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer
//   4-bit cycle counter used to bound an outstanding memory read.
//   Ports:
//     clk    : clock
//     reset  : synchronous active-low reset
//     i_clr  : clear count to zero (priority over i_en)
//     i_en   : count one more cycle
//     o_tc   : terminal count, high while the count equals TIMER_TC
// -----------------------------------------------------------------------------
module fetch_timer
  import instr_fetch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TIMER_W-1:0] r_count;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order in the simulator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign o_tc = (r_count == TIMER_TC);

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetches one instruction word per request from a level-handshake memory and
//   steers the program counter (increment after a fetch, load on a redirect).
//   Ports:
//     clk, reset (sync, active-low)
//     pc_in, fetch_start            : fetch request at pc_in (taken in IDLE)
//     branch_req, branch_target     : redirect request
//     mem_req, mem_addr             : read request, held until mem_ack
//     mem_ack, mem_rdata            : read completion with data
//     IR_out, IR_valid              : last accepted instruction + update pulse
//     PC_inc, PC_ld, PC_target      : PC control pulses
//     fetch_err                     : sticky error (misaligned PC or timeout)
//   All outputs are registered; every output value is computed in the
//   next-state logic and loaded on the same edge as the state transition.
// -----------------------------------------------------------------------------
module instruction_fetch
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] pc_in,
  input  logic              fetch_start,
  input  logic              branch_req,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] IR_out,
  output logic              IR_valid,
  output logic              PC_inc,
  output logic              PC_ld,
  output logic [WORD_W-1:0] PC_target,
  output logic              fetch_err
);

  fetch_state_e      r_state,      w_state_nxt;
  logic              r_mem_req,    w_mem_req_nxt;
  logic [WORD_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [WORD_W-1:0] r_ir_out,     w_ir_out_nxt;
  logic              r_ir_valid,   w_ir_valid_nxt;
  logic              r_pc_inc,     w_pc_inc_nxt;
  logic              r_pc_ld,      w_pc_ld_nxt;
  logic [WORD_W-1:0] r_pc_target,  w_pc_target_nxt;
  logic              r_fetch_err,  w_fetch_err_nxt;
  logic              r_pending,    w_pending_nxt;
  logic [WORD_W-1:0] r_saved_tgt,  w_saved_tgt_nxt;

  logic w_timer_clr;
  logic w_timer_en;
  logic w_timer_tc;
  logic w_pending_now;

  fetch_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_timer_clr),
    .i_en  (w_timer_en),
    .o_tc  (w_timer_tc)
  );

  // A redirect arriving in the same cycle as mem_ack still wins over the
  // fetched word, so it is folded into the pending decision immediately.
  assign w_pending_now = r_pending | branch_req;

  // NOTE: every variable is given a default before the case statement; a path
  // that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_ir_out_nxt    = r_ir_out;
    w_ir_valid_nxt  = 1'b0;
    w_pc_inc_nxt    = 1'b0;
    w_pc_ld_nxt     = 1'b0;
    w_pc_target_nxt = r_pc_target;
    w_fetch_err_nxt = r_fetch_err;
    w_pending_nxt   = r_pending;
    w_saved_tgt_nxt = r_saved_tgt;
    w_timer_clr     = 1'b1;
    w_timer_en      = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Redirect has priority; a simultaneous fetch request is dropped.
        if (branch_req) begin
          w_pc_ld_nxt     = 1'b1;
          w_pc_target_nxt = branch_target;
        end else if (fetch_start) begin
          if (is_word_aligned(pc_in)) begin
            w_mem_addr_nxt = pc_in;
            w_mem_req_nxt  = 1'b1;
            w_state_nxt    = WAIT;
          end else begin
            w_fetch_err_nxt = 1'b1;
            w_state_nxt     = ERR;
          end
        end
      end

      WAIT: begin
        w_timer_clr = 1'b0;
        if (branch_req) begin
          w_pending_nxt   = 1'b1;
          w_saved_tgt_nxt = branch_target;
        end
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_timer_clr   = 1'b1;
          w_state_nxt   = DONE;
          // DONE's pulses are loaded here so they are visible during DONE.
          if (w_pending_now) begin
            w_pc_ld_nxt     = 1'b1;
            w_pc_target_nxt = branch_req ? branch_target : r_saved_tgt;
          end else begin
            w_ir_out_nxt   = mem_rdata;
            w_ir_valid_nxt = 1'b1;
            w_pc_inc_nxt   = 1'b1;
          end
        end else if (w_timer_tc) begin
          w_mem_req_nxt   = 1'b0;
          w_fetch_err_nxt = 1'b1;
          w_pending_nxt   = 1'b0;
          w_timer_clr     = 1'b1;
          w_state_nxt     = ERR;
        end else begin
          w_timer_en = 1'b1;
        end
      end

      DONE: begin
        w_pending_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end

      ERR: begin
        w_mem_req_nxt   = 1'b0;
        w_fetch_err_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_ir_out    <= '0;
      r_ir_valid  <= 1'b0;
      r_pc_inc    <= 1'b0;
      r_pc_ld     <= 1'b0;
      r_pc_target <= '0;
      r_fetch_err <= 1'b0;
      r_pending   <= 1'b0;
      r_saved_tgt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_ir_out    <= w_ir_out_nxt;
      r_ir_valid  <= w_ir_valid_nxt;
      r_pc_inc    <= w_pc_inc_nxt;
      r_pc_ld     <= w_pc_ld_nxt;
      r_pc_target <= w_pc_target_nxt;
      r_fetch_err <= w_fetch_err_nxt;
      r_pending   <= w_pending_nxt;
      r_saved_tgt <= w_saved_tgt_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign IR_out    = r_ir_out;
  assign IR_valid  = r_ir_valid;
  assign PC_inc    = r_pc_inc;
  assign PC_ld     = r_pc_ld;
  assign PC_target = r_pc_target;
  assign fetch_err = r_fetch_err;

endmodule
